io_dmem_dma: RTL and testbench

IO_DMEM_DMA -- requirements
Module: io_dmem_dma

---
 rtl/io_dmem_dma.sv | 168 ++++++++++++++++
 tb/tb_io_dmem_dma.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_dmem_dma.sv
// Copies cmd_len words from src to dst in bursts of up to MAX_BURST_LEN (read burst to buffer, then write it).
// Latency: read request valid the cycle after cmd accept; done pulses the cycle after the final write-data beat.
// Backpressure: all channels valid/ready; valids and payloads hold until fire; cmd_ready only while idle.
module io_dmem_dma #(
    parameter int AWIDTH        = 14,
    parameter int DWIDTH        = 32,
    parameter int MAX_BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] cmd_src_addr,
    input  logic [AWIDTH-1:0] cmd_dst_addr,
    input  logic [31:0]       cmd_len,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] req_read_addr,
    output logic [31:0]       req_read_len,
    output logic              req_read_addr_valid,
    input  logic              req_read_addr_ready,
    input  logic [DWIDTH-1:0] resp_read_data,
    input  logic              resp_read_data_valid,
    output logic              resp_read_data_ready,
    output logic [AWIDTH-1:0] req_write_addr,
    output logic [31:0]       req_write_len,
    output logic              req_write_addr_valid,
    input  logic              req_write_addr_ready,
    output logic [DWIDTH-1:0] req_write_data,
    output logic              req_write_data_valid,
    input  logic              req_write_data_ready
);
    // IW must hold the value MAX_BURST_LEN (index parks at chunk after the last read beat)
    localparam int          IW      = $clog2(MAX_BURST_LEN + 1);
    localparam int          BW      = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1;
    localparam logic [31:0] MAX_LEN = 32'(MAX_BURST_LEN);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [31:0]       rem_q, rem_d, chunk_q, chunk_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DWIDTH-1:0] buf_q [MAX_BURST_LEN];

    logic        cmd_fire, rd_req_fire, rd_dat_fire, wr_req_fire, wr_dat_fire;
    logic        last_beat;
    logic [31:0] rem_after;

    function automatic logic [31:0] clamp_len(input logic [31:0] n);
        return (n > MAX_LEN) ? MAX_LEN : n;
    endfunction

    assign cmd_fire    = cmd_valid & cmd_ready;
    assign rd_req_fire = req_read_addr_valid & req_read_addr_ready;
    assign rd_dat_fire = resp_read_data_valid & resp_read_data_ready;
    assign wr_req_fire = req_write_addr_valid & req_write_addr_ready;
    assign wr_dat_fire = req_write_data_valid & req_write_data_ready;
    assign last_beat   = ({{(32-IW){1'b0}}, idx_q} == (chunk_q - 32'd1));
    assign rem_after   = rem_q - chunk_q;

    // Payloads come straight from registers so they cannot move while a valid is pending
    assign req_read_addr  = src_q;
    assign req_read_len   = chunk_q;
    assign req_write_addr = dst_q;
    assign req_write_len  = chunk_q;
    assign req_write_data = buf_q[idx_q[BW-1:0]];

    // State and datapath registers; reset abandons any command in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            chunk_q <= chunk_d;
            idx_q   <= idx_d;
        end
    end

    // Burst buffer: contents are don't-care out of reset, so no reset term
    always_ff @(posedge clk) begin
        if (rd_dat_fire) begin
            buf_q[idx_q[BW-1:0]] <= resp_read_data;
        end
    end

    // Next-state: strict read-burst / write-burst alternation per chunk
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = (cmd_len == 32'd0) ? DONE : RD_REQ;
            RD_REQ:  if (rd_req_fire) state_d = RD_DATA;
            RD_DATA: if (rd_dat_fire && last_beat) state_d = WR_REQ;
            WR_REQ:  if (wr_req_fire) state_d = WR_DATA;
            WR_DATA: if (wr_dat_fire && last_beat) state_d = (rem_after != 32'd0) ? RD_REQ : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: chunk is fixed whenever RD_REQ is entered, addresses wrap modulo 2^AWIDTH
    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        chunk_d = chunk_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    src_d   = cmd_src_addr;
                    dst_d   = cmd_dst_addr;
                    rem_d   = cmd_len;
                    chunk_d = clamp_len(cmd_len);
                    idx_d   = '0;
                end
            end
            RD_REQ:  if (rd_req_fire) idx_d = '0;
            RD_DATA: if (rd_dat_fire) idx_d = idx_q + 1'b1;
            WR_REQ:  if (wr_req_fire) idx_d = '0;
            WR_DATA: begin
                if (wr_dat_fire) begin
                    idx_d = idx_q + 1'b1;
                    if (last_beat) begin
                        src_d   = src_q + AWIDTH'(chunk_q);
                        dst_d   = dst_q + AWIDTH'(chunk_q);
                        rem_d   = rem_after;
                        chunk_d = clamp_len(rem_after);
                        idx_d   = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state only, so reset drops every valid at once
    always_comb begin
        cmd_ready            = 1'b0;
        busy                 = 1'b1;
        done                 = 1'b0;
        req_read_addr_valid  = 1'b0;
        resp_read_data_ready = 1'b0;
        req_write_addr_valid = 1'b0;
        req_write_data_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            RD_REQ:  req_read_addr_valid  = 1'b1;
            RD_DATA: resp_read_data_ready = 1'b1;
            WR_REQ:  req_write_addr_valid = 1'b1;
            WR_DATA: req_write_data_valid = 1'b1;
            DONE:    done                 = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_io_dmem_dma.sv
// Directed bench for io_dmem_dma with a behavioural DMem (mem[i]=i*100, fixed read latency, optional stalls).
// Latency: checks first read-request cycle and done-after-last-write timing.
// Backpressure: random ready/valid stalls verify payload stability and unchanged final memory.
module tb_io_dmem_dma;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int MB    = 8;
    localparam int LAT   = 10;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] cmd_src_addr, cmd_dst_addr;
    logic [31:0]   cmd_len;
    logic          cmd_valid, cmd_ready, busy, done;
    logic [AW-1:0] req_read_addr, req_write_addr;
    logic [31:0]   req_read_len, req_write_len;
    logic          req_read_addr_valid, req_read_addr_ready;
    logic [DW-1:0] resp_read_data;
    logic          resp_read_data_valid, resp_read_data_ready;
    logic          req_write_addr_valid, req_write_addr_ready;
    logic [DW-1:0] req_write_data;
    logic          req_write_data_valid, req_write_data_ready;

    always #5 clk = ~clk;

    io_dmem_dma #(.AWIDTH(AW), .DWIDTH(DW), .MAX_BURST_LEN(MB)) dut (
        .clk(clk), .rst(rst),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy), .done(done),
        .req_read_addr(req_read_addr), .req_read_len(req_read_len),
        .req_read_addr_valid(req_read_addr_valid), .req_read_addr_ready(req_read_addr_ready),
        .resp_read_data(resp_read_data), .resp_read_data_valid(resp_read_data_valid),
        .resp_read_data_ready(resp_read_data_ready),
        .req_write_addr(req_write_addr), .req_write_len(req_write_len),
        .req_write_addr_valid(req_write_addr_valid), .req_write_addr_ready(req_write_addr_ready),
        .req_write_data(req_write_data), .req_write_data_valid(req_write_data_valid),
        .req_write_data_ready(req_write_data_ready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [MEMSZ];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Request logs and DMem model state
    int rd_a[$], rd_l[$], wr_a[$], wr_l[$];
    bit rd_busy, wr_busy, resp_fired, stall_en;
    int rd_addr, rd_len, rd_cnt, rd_sent, lat;
    int wr_addr, wr_len, wr_cnt;
    int wd_total = 0, done_cnt = 0, done_edge = 0, last_wd_edge = -1;
    bit rv_st, wv_st, wd_st;
    logic [AW-1:0] sv_ra, sv_wa;
    logic [31:0]   sv_rl, sv_wl;
    logic [DW-1:0] sv_wd;

    initial begin : dmem_model
        req_read_addr_ready  = 1'b0;
        req_write_addr_ready = 1'b0;
        req_write_data_ready = 1'b0;
        resp_read_data_valid = 1'b0;
        resp_read_data       = '0;
        rd_busy = 0; wr_busy = 0; resp_fired = 0; lat = 0;
        rd_len = 0; rd_cnt = 0; rd_sent = 0; wr_len = 0; wr_cnt = 0;
        rv_st = 0; wv_st = 0; wd_st = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rd_busy = 0; wr_busy = 0; rd_cnt = 0; rd_sent = 0; rd_len = 0;
                wr_cnt = 0; wr_len = 0; lat = 0; resp_fired = 0;
                rv_st = 0; wv_st = 0; wd_st = 0;
            end else begin
                if (rv_st) begin
                    check_eq("rd_req_hold_vld", 32'(req_read_addr_valid), 1);
                    check_eq("rd_req_hold_addr", 32'(req_read_addr), 32'(sv_ra));
                    check_eq("rd_req_hold_len", req_read_len, sv_rl);
                end
                if (wv_st) begin
                    check_eq("wr_req_hold_vld", 32'(req_write_addr_valid), 1);
                    check_eq("wr_req_hold_addr", 32'(req_write_addr), 32'(sv_wa));
                    check_eq("wr_req_hold_len", req_write_len, sv_wl);
                end
                if (wd_st) begin
                    check_eq("wr_dat_hold_vld", 32'(req_write_data_valid), 1);
                    check_eq("wr_dat_hold_data", req_write_data, sv_wd);
                end
                rv_st = req_read_addr_valid && !req_read_addr_ready;
                wv_st = req_write_addr_valid && !req_write_addr_ready;
                wd_st = req_write_data_valid && !req_write_data_ready;
                sv_ra = req_read_addr;  sv_rl = req_read_len;
                sv_wa = req_write_addr; sv_wl = req_write_len;
                sv_wd = req_write_data;
                resp_fired = resp_read_data_valid && resp_read_data_ready;

                if (req_read_addr_valid && req_read_addr_ready) begin
                    check_eq("rd_while_busy", {30'd0, rd_busy, wr_busy}, 0);
                    check_eq("rd_before_write", 32'(rd_a.size() - wr_a.size()), 0);
                    rd_a.push_back(int'(req_read_addr));
                    rd_l.push_back(int'(req_read_len));
                    rd_busy = 1; rd_addr = int'(req_read_addr); rd_len = int'(req_read_len);
                    rd_cnt = 0; rd_sent = 0; lat = LAT;
                end
                if (resp_fired) begin
                    rd_cnt++;
                    if (rd_cnt >= rd_len) rd_busy = 0;
                end
                if (req_write_addr_valid && req_write_addr_ready) begin
                    check_eq("wr_while_busy", {30'd0, rd_busy, wr_busy}, 0);
                    wr_a.push_back(int'(req_write_addr));
                    wr_l.push_back(int'(req_write_len));
                    wr_busy = 1; wr_addr = int'(req_write_addr); wr_len = int'(req_write_len);
                    wr_cnt = 0;
                end
                if (req_write_data_valid && req_write_data_ready) begin
                    mem[(wr_addr + wr_cnt) % MEMSZ] = req_write_data;
                    wr_cnt++;
                    wd_total++;
                    last_wd_edge = cyc + 1;
                    if (wr_cnt >= wr_len) wr_busy = 0;
                end
                if (done) begin
                    done_cnt++;
                    done_edge = cyc;
                end
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                req_read_addr_ready  = 1'b0;
                req_write_addr_ready = 1'b0;
                req_write_data_ready = 1'b0;
                resp_read_data_valid = 1'b0;
            end else begin
                req_read_addr_ready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                req_write_addr_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                req_write_data_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!(resp_read_data_valid && !resp_fired)) begin
                    resp_read_data_valid = 1'b0;
                    if (rd_busy && rd_sent < rd_len && lat == 0 &&
                        (!stall_en || $urandom_range(0, 2) != 0)) begin
                        resp_read_data_valid = 1'b1;
                        resp_read_data       = mem[(rd_addr + rd_sent) % MEMSZ];
                        rd_sent++;
                    end
                end
                if (lat > 0) lat--;
            end
        end
    end

    task automatic issue_cmd(input int src, input int dst, input int len);
        int ok;
        @(posedge clk);
        #1;
        cmd_src_addr = AW'(src);
        cmd_dst_addr = AW'(dst);
        cmd_len      = 32'(len);
        cmd_valid    = 1'b1;
        ok = 0;
        for (int t = 0; t < 100 && ok == 0; t++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            @(posedge clk);
        end
        #1;
        cmd_valid = 1'b0;
        check_eq("cmd_accept", ok, 1);
    endtask

    task automatic run_cmd(input int src, input int dst, input int len);
        int d0, ok;
        d0 = done_cnt;
        issue_cmd(src, dst, len);
        if (len == 0) begin
            check_eq("len0_done", 32'(done), 1);
            check_eq("len0_rd_vld", 32'(req_read_addr_valid), 0);
            check_eq("len0_wr_vld", 32'(req_write_addr_valid), 0);
            check_eq("len0_wd_vld", 32'(req_write_data_valid), 0);
            @(posedge clk);
            #1;
            check_eq("len0_cmd_ready", 32'(cmd_ready), 1);
            check_eq("len0_done_drop", 32'(done), 0);
        end else begin
            check_eq("rd_vld_first", 32'(req_read_addr_valid), 1);
            check_eq("busy_after_cmd", 32'(busy), 1);
            check_eq("cmd_ready_busy", 32'(cmd_ready), 0);
        end
        ok = 0;
        for (int i = 0; i < 4000 && ok == 0; i++) begin
            @(negedge clk);
            if (done_cnt != d0) ok = 1;
        end
        check_eq("done_seen", ok, 1);
        if (len > 0) check_eq("done_latency", done_edge, last_wd_edge);
        repeat (3) @(negedge clk);
        check_eq("done_once", done_cnt - d0, 1);
    endtask

    task automatic chk_rd(input int i, input int a, input int l);
        check_eq("rd_present", 32'(i < rd_a.size()), 1);
        if (i < rd_a.size()) begin
            check_eq("rd_addr", rd_a[i], a);
            check_eq("rd_len", rd_l[i], l);
        end
    endtask

    task automatic chk_wr(input int i, input int a, input int l);
        check_eq("wr_present", 32'(i < wr_a.size()), 1);
        if (i < wr_a.size()) begin
            check_eq("wr_addr", wr_a[i], a);
            check_eq("wr_len", wr_l[i], l);
        end
    endtask

    task automatic clear_logs();
        rd_a.delete(); rd_l.delete(); wr_a.delete(); wr_l.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_rd_vld"}, 32'(req_read_addr_valid), 0);
        check_eq({tag, "_resp_rdy"}, 32'(resp_read_data_ready), 0);
        check_eq({tag, "_wr_vld"}, 32'(req_write_addr_valid), 0);
        check_eq({tag, "_wd_vld"}, 32'(req_write_data_valid), 0);
        check_eq({tag, "_rd_addr"}, 32'(req_read_addr), 0);
        check_eq({tag, "_rd_len"}, req_read_len, 0);
        check_eq({tag, "_wr_addr"}, 32'(req_write_addr), 0);
        check_eq({tag, "_wr_len"}, req_write_len, 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        int d0, nr, nw, ok;
        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'(i * 100);
        cmd_src_addr = '0; cmd_dst_addr = '0; cmd_len = '0; cmd_valid = 1'b0;
        stall_en = 0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single full burst
        clear_logs();
        run_cmd(10, 100, 8);
        check_eq("s1_nrd", rd_a.size(), 1);
        check_eq("s1_nwr", wr_a.size(), 1);
        chk_rd(0, 10, 8);
        chk_wr(0, 100, 8);
        for (int k = 0; k < 8; k++) check_eq("s1_mem", mem[100 + k], 32'((10 + k) * 100));

        // Multi-chunk with short tail
        clear_logs();
        run_cmd(0, 200, 20);
        check_eq("s2_nrd", rd_a.size(), 3);
        check_eq("s2_nwr", wr_a.size(), 3);
        chk_rd(0, 0, 8);   chk_rd(1, 8, 8);   chk_rd(2, 16, 4);
        chk_wr(0, 200, 8); chk_wr(1, 208, 8); chk_wr(2, 216, 4);
        for (int k = 0; k < 20; k++) check_eq("s2_mem", mem[200 + k], 32'(k * 100));

        // Zero-length command
        clear_logs();
        run_cmd(5, 600, 0);
        check_eq("s3_nrd", rd_a.size(), 0);
        check_eq("s3_nwr", wr_a.size(), 0);

        // Source wraps past the top of memory
        clear_logs();
        run_cmd(16376, 50, 16);
        check_eq("s4_nrd", rd_a.size(), 2);
        chk_rd(0, 16376, 8);
        chk_rd(1, 0, 8);
        chk_wr(0, 50, 8);
        chk_wr(1, 58, 8);
        for (int k = 0; k < 8; k++) check_eq("s4_mem_hi", mem[50 + k], 32'((16376 + k) * 100));
        for (int k = 0; k < 8; k++) check_eq("s4_mem_lo", mem[58 + k], 32'(k * 100));

        // Random stalls on every channel
        clear_logs();
        stall_en = 1;
        run_cmd(0, 400, 20);
        stall_en = 0;
        chk_rd(2, 16, 4);
        chk_wr(2, 416, 4);
        for (int k = 0; k < 20; k++) check_eq("s5_mem", mem[400 + k], 32'(k * 100));

        // Reset after the third write beat abandons the command
        clear_logs();
        wd_total = 0;
        d0 = done_cnt;
        issue_cmd(30, 500, 8);
        ok = 0;
        for (int i = 0; i < 500 && ok == 0; i++) begin
            @(posedge clk);
            if (wd_total >= 3) ok = 1;
        end
        check_eq("s6_reach_wd3", ok, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        nr = rd_a.size();
        nw = wr_a.size();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("s6_no_done", done_cnt - d0, 0);
        check_eq("s6_no_rd", rd_a.size() - nr, 0);
        check_eq("s6_no_wr", wr_a.size() - nw, 0);
        check_eq("s6_idle", 32'(busy), 0);
        check_eq("s6_wd_count", wd_total, 3);
        clear_logs();
        run_cmd(10, 300, 8);
        chk_rd(0, 10, 8);
        chk_wr(0, 300, 8);
        for (int k = 0; k < 8; k++) check_eq("s6_mem", mem[300 + k], 32'((10 + k) * 100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
